// File: rtl/packer.sv
// packer: assembles 2-bit symbols LSB-first into bytes behind a one-entry output register.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   unpacked_i, valid_i     input symbol and its valid
//   last_i                  frame end on the input symbol (used only with PACKER_LAST_EN)
//   ready_o                 a symbol can be accepted this cycle
//   packed_o, valid_o       assembled byte and its valid
//   last_o                  the byte closes a frame
//   ready_i                 downstream accepts packed_o
//   count_o                 symbols held in the accumulator
// Build option: define PACKER_LAST_EN to enable frame-end flushing on last_i.
module packer (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] unpacked_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       last_i,
    output logic [7:0] packed_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       last_o,
    output logic [1:0] count_o
);
    logic [1:0] cnt_q, cnt_d;
    logic [5:0] acc_q, acc_d;
    logic [7:0] out_q, out_d;
    logic       vld_q, vld_d;
    logic       last_q, last_d;
    logic       in_fire, out_fire, done, flush;
    logic [7:0] merged;

`ifdef PACKER_LAST_EN
    assign flush   = last_i;
    // A flush can complete a byte at any count, so any symbol needs a free output slot.
    assign ready_o = !vld_q || ready_i;
`else
    logic unused_last;
    assign unused_last = last_i;
    assign flush   = 1'b0;
    // Only the completing symbol needs room in the output register.
    assign ready_o = (cnt_q != 2'd3) || !vld_q || ready_i;
`endif

    always_comb begin
        in_fire  = valid_i && ready_o;
        out_fire = vld_q && ready_i;
        done     = in_fire && (cnt_q == 2'd3 || flush);
        // Upper slots of the accumulator are always zero, so this also zero-pads a flushed byte.
        merged   = {2'b00, acc_q} | (8'(unpacked_i) << {cnt_q, 1'b0});
        cnt_d    = done ? 2'd0 : in_fire ? cnt_q + 2'd1 : cnt_q;
        acc_d    = done ? 6'd0 : in_fire ? merged[5:0] : acc_q;
        out_d    = done ? merged : out_q;
        vld_d    = done || (vld_q && !out_fire);
        last_d   = done ? flush : last_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= 2'd0;
            acc_q  <= 6'd0;
            out_q  <= 8'h00;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign packed_o = out_q;
    assign valid_o  = vld_q;
    assign last_o   = last_q;
    assign count_o  = cnt_q;
endmodule

// File: tb/tb_packer.sv
// tb_packer: table vectors, directed corner sequences and random traffic against a queue model.
module tb_packer;
    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [1:0] unpacked_i = 2'd0;
    logic       valid_i = 1'b0;
    logic       last_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       ready_o, valid_o, last_o;
    logic [7:0] packed_o;
    logic [1:0] count_o;

    packer dut (
        .clk_i(clk), .reset_i(reset_i), .unpacked_i(unpacked_i), .valid_i(valid_i),
        .ready_o(ready_o), .last_i(last_i), .packed_o(packed_o), .valid_o(valid_o),
        .ready_i(ready_i), .last_o(last_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int n_acc  = 0;
    int part[$];
    logic [7:0] pend_b[$];
    logic       pend_l[$];
    logic [7:0] got[$];
    logic       inf, of;

    typedef struct {
        logic       v;
        logic [1:0] s;
        logic       r;
        logic       ev;
        logic [7:0] ep;
        logic [1:0] ec;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    // Apply inputs mid-cycle and compare outputs with the model state.
    task automatic drive(input logic v, input logic [1:0] s, input logic l, input logic r);
        logic er;
        @(negedge clk);
        valid_i = v; unpacked_i = s; last_i = l; ready_i = r;
        #1;
`ifdef PACKER_LAST_EN
        er = (pend_b.size() == 0) || r;
`else
        er = (part.size() != 3) || (pend_b.size() == 0) || r;
`endif
        chk("ready_o", {31'd0, ready_o}, {31'd0, er});
        chk("valid_o", {31'd0, valid_o}, {31'd0, pend_b.size() != 0});
        chk("count_o", {30'd0, count_o}, part.size());
        if (pend_b.size() != 0) begin
            chk("packed_o", {24'd0, packed_o}, {24'd0, pend_b[0]});
            chk("last_o", {31'd0, last_o}, {31'd0, pend_l[0]});
        end
        inf = v && ready_o;
        of  = valid_o && r;
        if (of) got.push_back(packed_o);
        if (inf) n_acc++;
    endtask

    // Advance one clock and update the model from the handshakes seen in drive.
    task automatic tick();
        logic [7:0] b;
        @(posedge clk);
        if (of) begin
            void'(pend_b.pop_front());
            void'(pend_l.pop_front());
        end
        if (inf) begin
            part.push_back(int'(unpacked_i));
`ifdef PACKER_LAST_EN
            if (part.size() == 4 || last_i) begin
`else
            if (part.size() == 4) begin
`endif
                b = 8'h00;
                foreach (part[k]) b = b + 8'(part[k] * (4 ** k));
                pend_b.push_back(b);
`ifdef PACKER_LAST_EN
                pend_l.push_back(last_i);
`else
                pend_l.push_back(1'b0);
`endif
                part.delete();
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] s, input logic l, input logic r);
        drive(v, s, l, r);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        @(posedge clk);
        part.delete(); pend_b.delete(); pend_l.delete();
        @(negedge clk);
        #1;
        chk("rst count_o", {30'd0, count_o}, 0);
        chk("rst valid_o", {31'd0, valid_o}, 0);
        chk("rst packed_o", {24'd0, packed_o}, 0);
        chk("rst last_o", {31'd0, last_o}, 0);
        reset_i = 1'b0;
        #1;
        chk("post-rst ready_o", {31'd0, ready_o}, 1);
    endtask

    initial begin
        logic [1:0] rt[8];
        int budget;
        tbl[0] = '{1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 2'd1};
        tbl[2] = '{1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 2'd2};
        tbl[3] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 2'd3};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b1, 8'h36, 2'd0};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0};
        rt = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0};

        repeat (2) @(posedge clk);
        do_reset();

        // Basic packing 2,1,3,0 -> 8'h36 for exactly one cycle.
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s, 1'b0, tbl[i].r);
            chk($sformatf("tbl%0d valid_o", i), {31'd0, valid_o}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d count_o", i), {30'd0, count_o}, {30'd0, tbl[i].ec});
            if (tbl[i].ev) chk($sformatf("tbl%0d packed_o", i), {24'd0, packed_o}, {24'd0, tbl[i].ep});
            tick();
        end

        // Round trip of A5, 3C as LSB-first symbols at full rate.
        got.delete();
        foreach (rt[i]) cyc(1'b1, rt[i], 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk("rt count", got.size(), 2);
        if (got.size() == 2) begin
            chk("rt byte0", {24'd0, got[0]}, 32'hA5);
            chk("rt byte1", {24'd0, got[1]}, 32'h3C);
        end

        // Backpressure: stall 10 cycles offering symbols of 1.
        got.delete();
        n_acc = 0;
        repeat (10) cyc(1'b1, 2'd1, 1'b0, 1'b0);
`ifndef PACKER_LAST_EN
        chk("bp accepted", n_acc, 7);
        chk("bp count_o", {30'd0, count_o}, 3);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        chk("bp ready_o", {31'd0, ready_o}, 0);
        chk("bp held", {24'd0, packed_o}, 32'h55);
        tick();
        // Drain and complete in the same cycle: valid_o must not drop.
        drive(1'b1, 2'd1, 1'b0, 1'b1);
        chk("drain+complete fire", {31'd0, inf && of}, 1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        chk("no bubble valid_o", {31'd0, valid_o}, 1);
        tick();
`endif
        budget = 20;
        while (n_acc < 8 && budget > 0) begin
            cyc(1'b1, 2'd1, 1'b0, 1'b1);
            budget--;
        end
        chk("bp budget", {31'd0, n_acc >= 8}, 1);
        repeat (3) cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk("bp bytes", got.size(), 2);
        if (got.size() == 2) begin
            chk("bp byte0", {24'd0, got[0]}, 32'h55);
            chk("bp byte1", {24'd0, got[1]}, 32'h55);
        end

`ifdef PACKER_LAST_EN
        // Flush after two symbols, then the next byte starts at slot 0.
        got.delete();
        cyc(1'b1, 2'd3, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b1, 1'b1);
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        chk("flush packed_o", {24'd0, packed_o}, 32'h0B);
        chk("flush last_o", {31'd0, last_o}, 1);
        tick();
        repeat (4) cyc(1'b1, 2'd1, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk("flush bytes", got.size(), 2);
        if (got.size() == 2) chk("after flush", {24'd0, got[1]}, 32'h55);
`endif

        // Reset mid-byte discards the partial symbols.
        repeat (2) cyc(1'b1, 2'd3, 1'b0, 1'b1);
        do_reset();
        got.delete();
        repeat (4) cyc(1'b1, 2'd1, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk("rst bytes", got.size(), 1);
        if (got.size() == 1) chk("rst byte", {24'd0, got[0]}, 32'h55);

        // Random traffic against the model.
        repeat (400) begin
`ifdef PACKER_LAST_EN
            cyc($urandom % 4 != 0, 2'($urandom), $urandom % 5 == 0, $urandom % 3 != 0);
`else
            cyc($urandom % 4 != 0, 2'($urandom), 1'($urandom), $urandom % 3 != 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/packer.md
PACKER -- requirements
Module: packer

Interface
REQ-001 SHALL have no parameters; symbol width is fixed at 2 bits and byte width at 8 bits.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port unpacked_i, input, 2 bits: input symbol.
REQ-005 SHALL have port valid_i, input, 1 bit: unpacked_i (and last_i) valid.
REQ-006 SHALL have port ready_o, output, 1 bit: packer can accept a symbol this cycle.
REQ-007 SHALL have port last_i, input, 1 bit: final symbol of a frame, qualified by valid_i.
REQ-008 SHALL have port packed_o, output, 8 bits: assembled byte.
REQ-009 SHALL have port valid_o, output, 1 bit: packed_o valid.
REQ-010 SHALL have port ready_i, input, 1 bit: downstream accepts packed_o.
REQ-011 SHALL have port last_o, output, 1 bit: packed_o closes a frame.
REQ-012 SHALL have port count_o, output, 2 bits: symbols currently held in the accumulator, 0..3.

Function
REQ-013 SHALL accept a symbol when valid_i && ready_o (in_fire) and emit a byte when valid_o && ready_i (out_fire).
REQ-014 SHALL place the k-th accepted symbol of a byte (k = 0..3) at packed_o[2k+1:2k], LSB-first, the exact inverse of the team's byte-to-2-bit unpacker.
REQ-015 SHALL hold a 2-bit rolling symbol counter: +1 per in_fire, wrap 3->0 on byte completion; count_o equals the counter.
REQ-016 SHALL complete a byte on in_fire with counter == 3, loading the full byte into a single-entry output register; valid_o rises the next cycle (latency 1 cycle from the 4th accept).
REQ-017 SHALL clear the accumulator and counter to 0 on byte completion so stale bits never appear in a later byte.
REQ-018 SHALL hold packed_o and last_o stable while valid_o && !ready_i.
REQ-019 SHALL, on out_fire without a same-cycle completion, deassert valid_o the next cycle.
REQ-020 SHALL, on out_fire coinciding with a completion, load the new byte and keep valid_o high (no bubble).
REQ-021 SHALL drive ready_o without any combinational dependence on valid_i, unpacked_i or last_i.
REQ-022 SHALL sustain one symbol per cycle, i.e. one byte every 4 cycles, while ready_i is held high.
REQ-023 SHALL, with the output register full and stalled, keep accumulating symbols 0..2 and block only the completing symbol.

Reset
REQ-024 SHALL, while reset_i is high, set counter/count_o = 0, accumulator = 0, packed_o = 8'h00, valid_o = 0 and last_o = 0.
REQ-025 SHALL, on reset mid-byte or with a pending output, discard all partial and pending data; the first byte after reset contains only post-reset symbols.
REQ-026 SHALL drive ready_o = 1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL compile frame-end flushing in when the macro PACKER_LAST_EN is defined.
REQ-028 SHALL, with PACKER_LAST_EN defined: treat in_fire with last_i = 1 as a completion at any counter value; zero-pad unfilled upper symbol slots; set last_o = 1 for that byte; reset the counter to 0.
REQ-029 SHALL, with PACKER_LAST_EN defined, drive ready_o = !valid_o || ready_i.
REQ-030 SHALL, without PACKER_LAST_EN: ignore last_i; tie last_o to 0; drive ready_o = (counter != 3) || !valid_o || ready_i.

Verification
REQ-031 SHALL cover basic packing: ready_i = 1; symbols 2,1,3,0 on consecutive cycles -> packed_o = 8'h36, valid_o high exactly 1 cycle, on the cycle after the 4th accept.
REQ-032 SHALL cover round-trip: bytes 8'hA5, 8'h3C through the unpacker into this packer -> output 8'hA5, 8'h3C in order, 1 symbol/cycle, no bubbles.
REQ-033 SHALL cover backpressure: ready_i = 0 for 10 cycles, 8 symbols of 1 offered -> 8'h55 held stable; 3 more symbols accepted; ready_o low (without PACKER_LAST_EN); on ready_i = 1 both bytes 8'h55 emitted with no loss or duplication.
REQ-034 SHALL cover flush, with PACKER_LAST_EN defined: symbols 3,2, last_i on the 2nd -> packed_o = 8'h0B with last_o = 1; the next byte starts at slot 0.
REQ-035 SHALL cover reset mid-operation: 2 symbols of 3, then a 1-cycle reset, then symbols 1,1,1,1 -> single byte 8'h55 and count_o = 0 after reset.
REQ-036 SHALL cover simultaneous drain and complete: valid_o high, ready_i = 1 in the same cycle as the 4th symbol accept -> valid_o stays high and the new byte appears the next cycle.
